// File: rtl/con_byte_bridge_pkg.sv
// Shared opcodes, response bytes and FSM state encoding for the byte-stream
// command bridge into the datamem controller port.
package con_byte_bridge_pkg;

  localparam logic [7:0] CMD_RD    = 8'h50;
  localparam logic [3:0] CMD_WR_HI = 4'hA;
  localparam logic [7:0] RSP_ACK   = 8'hAC;
  localparam logic [7:0] RSP_ERR   = 8'hEE;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR_H,
    ST_ADDR_L,
    ST_DATA,
    ST_WR,
    ST_RD_ISSUE,
    ST_RD_TX,
    ST_ACK_TX,
    ST_ERR_TX
  } state_t;

  // 0xA0 carries no byte enables, so it is rejected like any unknown opcode.
  function automatic logic is_wr_cmd(input logic [7:0] cmd);
    return (cmd[7:4] == CMD_WR_HI) && (cmd[3:0] != 4'h0);
  endfunction

endpackage

// File: rtl/con_byte_bridge.sv
// Framed byte-stream command engine: decodes read/write frames from a serial
// PHY and drives the datamem controller port, returning data or ack/err bytes.
module con_byte_bridge
  import con_byte_bridge_pkg::*;
#(
  parameter int RD_LAT      = 1,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic        con_clk,
  input  logic        nrst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic [3:0]  con_write,
  output logic [9:0]  con_addr,
  output logic [31:0] con_in,
  input  logic [31:0] con_out,
  output logic        busy
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int LW = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);
  localparam logic [TW-1:0] TOUT_MAX = TW'(TIMEOUT_CYC);
  localparam logic [LW-1:0] RD_LAT_C = LW'(RD_LAT);

  state_t          state_reg;
  logic [1:0]      byte_cnt_reg;
  logic [TW-1:0]   tout_reg;
  logic [LW-1:0]   rd_cnt_reg;
  logic [3:0]      wen_reg;
  logic [1:0]      addr_hi_reg;
  logic            bad_addr_reg;
  logic            is_wr_reg;
  logic [31:0]     shift_reg;

  logic rx_fire;
  logic tx_fire;
  logic in_frame;
  logic timed_out;

  assign rx_ready  = (state_reg == ST_IDLE) || (state_reg == ST_ADDR_H) ||
                     (state_reg == ST_ADDR_L) || (state_reg == ST_DATA);
  assign busy      = (state_reg != ST_IDLE);
  assign rx_fire   = rx_valid & rx_ready;
  assign tx_fire   = tx_valid & tx_ready;
  assign in_frame  = (state_reg == ST_ADDR_H) || (state_reg == ST_ADDR_L) ||
                     (state_reg == ST_DATA);
  assign timed_out = (tout_reg == TOUT_MAX);

  always_ff @(posedge con_clk) begin
    if (!nrst) begin
      state_reg    <= ST_IDLE;
      byte_cnt_reg <= '0;
      tout_reg     <= '0;
      rd_cnt_reg   <= '0;
      wen_reg      <= '0;
      addr_hi_reg  <= '0;
      bad_addr_reg <= 1'b0;
      is_wr_reg    <= 1'b0;
      shift_reg    <= '0;
      tx_valid     <= 1'b0;
      tx_data      <= '0;
      con_write    <= '0;
      con_addr     <= '0;
      con_in       <= '0;
    end else begin
      con_write <= '0;

      // Inter-byte watchdog only runs while a frame is being received.
      if (rx_fire)
        tout_reg <= '0;
      else if (in_frame && !timed_out)
        tout_reg <= tout_reg + 1'b1;

      case (state_reg)
        ST_IDLE: begin
          if (rx_fire) begin
            if (rx_data == CMD_RD) begin
              is_wr_reg <= 1'b0;
              state_reg <= ST_ADDR_H;
            end else if (is_wr_cmd(rx_data)) begin
              is_wr_reg <= 1'b1;
              wen_reg   <= rx_data[3:0];
              state_reg <= ST_ADDR_H;
            end else begin
              tx_valid  <= 1'b1;
              tx_data   <= RSP_ERR;
              state_reg <= ST_ERR_TX;
            end
          end
        end

        ST_ADDR_H: begin
          if (rx_fire) begin
            addr_hi_reg  <= rx_data[1:0];
            bad_addr_reg <= |rx_data[7:2];
            state_reg    <= ST_ADDR_L;
          end else if (timed_out) begin
            state_reg <= ST_IDLE;
          end
        end

        ST_ADDR_L: begin
          if (rx_fire) begin
            byte_cnt_reg <= '0;
            if (!bad_addr_reg)
              con_addr <= {addr_hi_reg, rx_data};
            if (is_wr_reg) begin
              state_reg <= ST_DATA;
            end else if (bad_addr_reg) begin
              tx_valid  <= 1'b1;
              tx_data   <= RSP_ERR;
              state_reg <= ST_ERR_TX;
            end else begin
              rd_cnt_reg <= '0;
              state_reg  <= ST_RD_ISSUE;
            end
          end else if (timed_out) begin
            state_reg <= ST_IDLE;
          end
        end

        ST_DATA: begin
          if (rx_fire) begin
            con_in       <= {con_in[23:0], rx_data};
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
            if (byte_cnt_reg == 2'd3) begin
              if (bad_addr_reg) begin
                tx_valid  <= 1'b1;
                tx_data   <= RSP_ERR;
                state_reg <= ST_ERR_TX;
              end else begin
                con_write <= wen_reg;
                state_reg <= ST_WR;
              end
            end
          end else if (timed_out) begin
            state_reg <= ST_IDLE;
          end
        end

        ST_WR: begin
          tx_valid  <= 1'b1;
          tx_data   <= RSP_ACK;
          state_reg <= ST_ACK_TX;
        end

        ST_RD_ISSUE: begin
          if (rd_cnt_reg == RD_LAT_C) begin
            tx_valid     <= 1'b1;
            tx_data      <= con_out[31:24];
            shift_reg    <= {con_out[23:0], 8'h00};
            byte_cnt_reg <= '0;
            state_reg    <= ST_RD_TX;
          end else begin
            rd_cnt_reg <= rd_cnt_reg + 1'b1;
          end
        end

        ST_RD_TX: begin
          if (tx_fire) begin
            if (byte_cnt_reg == 2'd3) begin
              tx_valid  <= 1'b0;
              state_reg <= ST_IDLE;
            end else begin
              tx_data      <= shift_reg[31:24];
              shift_reg    <= {shift_reg[23:0], 8'h00};
              byte_cnt_reg <= byte_cnt_reg + 2'd1;
            end
          end
        end

        ST_ACK_TX, ST_ERR_TX: begin
          if (tx_fire) begin
            tx_valid  <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_con_byte_bridge.sv
// Self-checking bench for con_byte_bridge: frame-level reference model with a
// separate memory image, plus a port-B memory that answers with 1-cycle latency.
module tb_con_byte_bridge;

  localparam int RD_LAT  = 1;
  localparam int TOUT    = 16;

  logic        con_clk = 1'b0;
  logic        nrst = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b1;
  logic [3:0]  con_write;
  logic [9:0]  con_addr;
  logic [31:0] con_in;
  logic [31:0] con_out = 32'h0;
  logic        busy;

  con_byte_bridge #(.RD_LAT(RD_LAT), .TIMEOUT_CYC(TOUT)) dut (
    .con_clk  (con_clk),
    .nrst     (nrst),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .con_write(con_write),
    .con_addr (con_addr),
    .con_in   (con_in),
    .con_out  (con_out),
    .busy     (busy)
  );

  always #5 con_clk = ~con_clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];

  logic [7:0]  frame_q[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  got_tx[$];
  logic [45:0] exp_wr[$];
  logic [45:0] got_wr[$];

  int  rx_acc_cyc   = 0;
  int  last_tx_acc  = 0;
  int  first_tx_cyc = 0;
  int  wr_cyc       = 0;
  bit  tx_seen      = 1'b0;
  bit  txr_rand     = 1'b0;
  int  gap_max      = 0;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = 32'h0;
      ref_mem[i] = 32'h0;
    end
  end

  always @(posedge con_clk) cyc++;

  // Datamem port B stand-in: registered read, byte-enabled write.
  always @(posedge con_clk) begin
    for (int b = 0; b < 4; b++)
      if (con_write[b]) mem[con_addr][8*b +: 8] <= con_in[8*b +: 8];
    con_out <= mem[con_addr];
  end

  always @(posedge con_clk) begin
    #1;
    if (txr_rand) tx_ready = 1'($urandom_range(0, 1));
  end

  always @(negedge con_clk) begin
    if (tx_valid && tx_ready) begin
      got_tx.push_back(tx_data);
      last_tx_acc = cyc + 1;
    end
    if (tx_valid && !tx_seen) begin
      tx_seen      = 1'b1;
      first_tx_cyc = cyc;
    end
    if (con_write != 4'h0) begin
      got_wr.push_back({con_write, con_addr, con_in});
      wr_cyc = cyc;
    end
  end

  // Frame-level reference: decides the reply and the memory effect of frame_q.
  task automatic predict();
    logic [7:0]  cmd;
    logic [9:0]  addr;
    logic        bad_a;
    logic [31:0] w;
    cmd = frame_q[0];
    if (frame_q.size() >= 3) begin
      addr  = {frame_q[1][1:0], frame_q[2]};
      bad_a = (frame_q[1] > 8'h03);
    end else begin
      addr  = '0;
      bad_a = 1'b0;
    end
    if (cmd == 8'h50) begin
      if (bad_a) exp_tx.push_back(8'hEE);
      else begin
        w = ref_mem[addr];
        for (int i = 3; i >= 0; i--) exp_tx.push_back(w[8*i +: 8]);
      end
    end else if (cmd >= 8'hA1 && cmd <= 8'hAF) begin
      w = {frame_q[3], frame_q[4], frame_q[5], frame_q[6]};
      if (bad_a) exp_tx.push_back(8'hEE);
      else begin
        for (int b = 0; b < 4; b++)
          if (cmd[b]) ref_mem[addr][8*b +: 8] = w[8*b +: 8];
        exp_wr.push_back({cmd[3:0], addr, w});
        exp_tx.push_back(8'hAC);
      end
    end else begin
      exp_tx.push_back(8'hEE);
    end
  endtask

  task automatic begin_check();
    exp_tx.delete();
    got_tx.delete();
    exp_wr.delete();
    got_wr.delete();
    tx_seen = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge con_clk);
      ok = rx_ready;
      @(posedge con_clk);
      #1;
    end
    rx_acc_cyc = cyc;
    rx_valid   = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL rx_accept byte=%02h: not accepted within 300 cycles", b);
    end
  endtask

  task automatic send_frame();
    for (int i = 0; i < frame_q.size(); i++) begin
      if (gap_max > 0)
        repeat ($urandom_range(0, gap_max)) begin @(posedge con_clk); #1; end
      send_byte(frame_q[i]);
    end
  endtask

  task automatic finish_check(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge con_clk);
      if (!busy && !tx_valid) ok = 1'b1;
    end
    @(posedge con_clk);
    #1;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s idle: bridge still busy after 400 cycles", name);
    end
    total++;
    if (got_tx.size() !== exp_tx.size()) begin
      bad++;
      $display("FAIL %s tx_count: got %0d need %0d", name, got_tx.size(), exp_tx.size());
    end
    for (int i = 0; i < exp_tx.size() && i < got_tx.size(); i++) begin
      total++;
      if (got_tx[i] !== exp_tx[i]) begin
        bad++;
        $display("FAIL %s tx[%0d]: got %02h need %02h", name, i, got_tx[i], exp_tx[i]);
      end
    end
    total++;
    if (got_wr.size() !== exp_wr.size()) begin
      bad++;
      $display("FAIL %s wr_count: got %0d need %0d", name, got_wr.size(), exp_wr.size());
    end
    for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++) begin
      total++;
      if (got_wr[i] !== exp_wr[i]) begin
        bad++;
        $display("FAIL %s wr[%0d]: got en/addr/data %h need %h", name, i, got_wr[i], exp_wr[i]);
      end
    end
    $display("frame %s: tx_bytes=%0d writes=%0d", name, got_tx.size(), got_wr.size());
  endtask

  task automatic run_frame(input string name);
    begin_check();
    predict();
    send_frame();
    finish_check(name);
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    repeat (3) begin @(posedge con_clk); #1; end
    @(negedge con_clk);
    total++;
    if (rx_ready !== 1'b1) begin bad++; $display("FAIL reset_rx_ready: got %b need 1", rx_ready); end
    total++;
    if ({tx_valid, tx_data, busy} !== 10'h0) begin
      bad++; $display("FAIL reset_tx: got valid=%b data=%02h busy=%b need 0", tx_valid, tx_data, busy);
    end
    total++;
    if ({con_write, con_addr, con_in} !== 46'h0) begin
      bad++; $display("FAIL reset_con: got we=%h addr=%h in=%h need 0", con_write, con_addr, con_in);
    end
    @(posedge con_clk);
    #1;
    nrst = 1'b1;
    $display("reset released at cycle %0d", cyc);
  endtask

  task automatic test_write_basic();
    frame_q = '{8'hAF, 8'h00, 8'h12, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_frame("write_AF");
    total++;
    if (first_tx_cyc !== wr_cyc + 1) begin
      bad++; $display("FAIL wr_ack_latency: got tx at %0d, write at %0d need +1", first_tx_cyc, wr_cyc);
    end
    total++;
    if ({con_addr, con_in} !== {10'h012, 32'hDEADBEEF}) begin
      bad++; $display("FAIL wr_hold: got addr=%h in=%h need 012/deadbeef", con_addr, con_in);
    end
  endtask

  task automatic test_write_read();
    frame_q = '{8'hA3, 8'h01, 8'hFF, 8'h11, 8'h22, 8'h33, 8'h44};
    run_frame("write_A3");
    frame_q = '{8'h50, 8'h01, 8'hFF};
    run_frame("read_1FF");
    total++;
    if (first_tx_cyc - rx_acc_cyc !== RD_LAT + 1) begin
      bad++; $display("FAIL rd_latency: got %0d need %0d", first_tx_cyc - rx_acc_cyc, RD_LAT + 1);
    end
    total++;
    if ({got_tx[0], got_tx[1], got_tx[2], got_tx[3]} !== 32'h00003344) begin
      bad++; $display("FAIL rd_word_1FF: got %02h%02h%02h%02h need 00003344",
                      got_tx[0], got_tx[1], got_tx[2], got_tx[3]);
    end
  endtask

  task automatic test_invalid();
    frame_q = '{8'h7E};
    run_frame("invalid_7E");
    frame_q = '{8'hA0};
    run_frame("invalid_A0");
    frame_q = '{8'h50, 8'h00, 8'h00};
    run_frame("read_000");
  endtask

  task automatic test_bad_addr();
    frame_q = '{8'h50, 8'h04, 8'h00};
    run_frame("badaddr_rd");
    frame_q = '{8'hAF, 8'h80, 8'h12, 8'h01, 8'h02, 8'h03, 8'h04};
    run_frame("badaddr_wr");
    frame_q = '{8'h50, 8'h00, 8'h12};
    run_frame("read_012");
  endtask

  task automatic test_timeout();
    begin_check();
    send_byte(8'h50);
    send_byte(8'h01);
    repeat (TOUT + 24) begin @(posedge con_clk); #1; end
    @(negedge con_clk);
    total++;
    if (busy !== 1'b0 || rx_ready !== 1'b1) begin
      bad++; $display("FAIL timeout_idle: got busy=%b rx_ready=%b need 0/1", busy, rx_ready);
    end
    @(posedge con_clk);
    #1;
    finish_check("timeout_abandon");
    // A stall shorter than the limit must not abandon the frame.
    begin_check();
    frame_q = '{8'h50, 8'h01, 8'hFF};
    predict();
    send_byte(8'h50);
    send_byte(8'h01);
    repeat (TOUT - 6) begin @(posedge con_clk); #1; end
    send_byte(8'hFF);
    finish_check("near_timeout_read");
  endtask

  task automatic test_backpressure();
    bit ok;
    frame_q = '{8'hAF, 8'h02, 8'h34, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
    run_frame("write_234");
    begin_check();
    frame_q = '{8'h50, 8'h02, 8'h34};
    predict();
    tx_ready = 1'b0;
    send_frame();
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge con_clk);
      ok = tx_valid;
    end
    total++;
    if (!ok) begin bad++; $display("FAIL bp_tx_valid: no tx_valid within 20 cycles"); end
    rx_data  = 8'h50;
    rx_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge con_clk);
      total++;
      if (tx_data !== exp_tx[0] || tx_valid !== 1'b1) begin
        bad++; $display("FAIL bp_hold[%0d]: got valid=%b data=%02h need 1/%02h", i, tx_valid, tx_data, exp_tx[0]);
      end
      total++;
      if (rx_ready !== 1'b0) begin
        bad++; $display("FAIL bp_rx_ready[%0d]: got %b need 0", i, rx_ready);
      end
    end
    @(posedge con_clk);
    #1;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    finish_check("bp_read_234");
  endtask

  task automatic test_reset_mid_data();
    begin_check();
    send_byte(8'hAF);
    send_byte(8'h00);
    send_byte(8'h10);
    send_byte(8'hAA);
    send_byte(8'hBB);
    nrst = 1'b0;
    @(posedge con_clk);
    #1;
    @(negedge con_clk);
    total++;
    if ({rx_ready, tx_valid, tx_data, busy, con_write, con_addr, con_in} !== {1'b1, 56'h0}) begin
      bad++; $display("FAIL midreset_outputs: got rdy=%b tv=%b td=%02h busy=%b we=%h addr=%h in=%h need 1/0",
                      rx_ready, tx_valid, tx_data, busy, con_write, con_addr, con_in);
    end
    @(posedge con_clk);
    #1;
    nrst = 1'b1;
    repeat (5) begin @(posedge con_clk); #1; end
    finish_check("midreset_abandon");
    frame_q = '{8'h50, 8'h00, 8'h10};
    run_frame("read_010_after_reset");
  endtask

  task automatic test_back_to_back();
    int tx_end;
    begin_check();
    tx_ready = 1'b1;
    frame_q = '{8'h50, 8'h00, 8'h12};
    predict();
    send_frame();
    frame_q = '{8'hA5, 8'h00, 8'h12, 8'h55, 8'h66, 8'h77, 8'h88};
    predict();
    send_byte(frame_q[0]);
    tx_end = last_tx_acc;
    total++;
    if (rx_acc_cyc !== tx_end + 1) begin
      bad++; $display("FAIL b2b_cmd_accept: got cycle %0d need %0d", rx_acc_cyc, tx_end + 1);
    end
    for (int i = 1; i < frame_q.size(); i++) send_byte(frame_q[i]);
    finish_check("back_to_back");
  endtask

  task automatic test_random();
    int kind;
    logic [7:0] c;
    txr_rand = 1'b1;
    gap_max  = 4;
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 99);
      if (kind < 35) begin
        frame_q = '{8'h50, 8'($urandom_range(0, 3)), 8'($urandom_range(0, 7) | 8'hF8 * (n % 2))};
      end else if (kind < 70) begin
        c = 8'hA0 | 8'($urandom_range(1, 15));
        frame_q = '{c, 8'($urandom_range(0, 3)), 8'($urandom_range(0, 7) | 8'hF8 * (n % 2)),
                    8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
      end else if (kind < 80) begin
        do c = 8'($urandom); while (c == 8'h50 || (c >= 8'hA1 && c <= 8'hAF));
        frame_q = '{c};
      end else if (kind < 90) begin
        frame_q = '{8'h50, 8'($urandom_range(4, 255)), 8'($urandom)};
      end else begin
        frame_q = '{8'hAF, 8'($urandom_range(4, 255)), 8'($urandom),
                    8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
      end
      run_frame($sformatf("random_%0d", n));
    end
    txr_rand = 1'b0;
    gap_max  = 0;
    @(posedge con_clk);
    #1;
    tx_ready = 1'b1;
  endtask

  initial begin
    #1;
    test_reset();
    test_write_basic();
    test_write_read();
    test_invalid();
    test_bad_addr();
    test_timeout();
    test_backpressure();
    test_reset_mid_data();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
